e_mdu: RTL and testbench

- Execute-stage multiply/divide unit; sits beside the ALU, directly upstream of the E/M pipeline register.
- Holds the architectural HI/LO registers and runs mult/multu/div/divu with fixed multi-cycle latency.
- Services mfhi/mflo/mthi/mtlo.
- Exposes a busy/stall request so the hazard unit freezes F/D while an MD instruction is pending; MDOUT is muxed into ALUOUT_E.

---
 rtl/mdu_pkg.sv | 53 +++++
 rtl/e_mdu_if.sv | 28 ++
 rtl/mdu_arith.sv | 69 ++++++
 rtl/e_mdu.sv | 82 ++++++++
 tb/tb_e_mdu.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared op encodings and constants for the E-stage multiply/divide unit
//
// Optional feature macro: MDU_MADD_EN (enables MADD/MADDU/MSUB/MSUBU decoding).
// Contents:
//   MDU_CNT_W  - width of the busy down-counter
//   md_op_e    - md_op encodings
//   is_md_op   - any op that must hold F/D while it is presented in E
//   is_mul_op  - ops that run for MULT_CYCLES
//   is_div_op  - ops that run for DIV_CYCLES
package mdu_pkg;

    localparam int MDU_CNT_W = 5;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MFHI  = 4'd5,
        MD_MFLO  = 4'd6,
        MD_MTHI  = 4'd7,
        MD_MTLO  = 4'd8,
        MD_MADD  = 4'd9,
        MD_MADDU = 4'd10,
        MD_MSUB  = 4'd11,
        MD_MSUBU = 4'd12
    } md_op_e;

    function automatic logic is_mul_op(input logic [3:0] op);
        logic r;
        r = 1'b0;
        case (op)
            MD_MULT, MD_MULTU: r = 1'b1;
`ifdef MDU_MADD_EN
            MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: r = 1'b1;
`endif
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_md_op(input logic [3:0] op);
        return is_mul_op(op) || is_div_op(op) ||
               (op == MD_MFHI) || (op == MD_MFLO) ||
               (op == MD_MTHI) || (op == MD_MTLO);
    endfunction

endpackage

// File: rtl/e_mdu_if.sv
// rtl/e_mdu_if.sv - E-stage multiply/divide unit signal bundle
//
// Signals:
//   md_en, md_op[3:0], A[31:0], B[31:0]  - request side (master drives)
//   busy, stall_req                     - status back to hazard unit
//   HI[31:0], LO[31:0], MDOUT[31:0]     - architectural registers and move-from result
// Modports: master (E-stage issue logic / bench), slave (e_mdu).
interface e_mdu_if;
    logic        md_en;
    logic [3:0]  md_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        stall_req;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MDOUT;

    modport master (
        output md_en, md_op, A, B,
        input  busy, stall_req, HI, LO, MDOUT
    );

    modport slave (
        input  md_en, md_op, A, B,
        output busy, stall_req, HI, LO, MDOUT
    );
endinterface

// File: rtl/mdu_arith.sv
// rtl/mdu_arith.sv - combinational 64-bit {HI,LO} result generator for mult/div/madd
//
// Optional feature macro: MDU_MADD_EN (adds accumulate/subtract forms).
// Ports:
//   i_op[3:0]   - md_op of the instruction being accepted
//   i_a, i_b    - operands (rs, rt)
//   i_hi, i_lo  - current HI/LO (accumulate base, and kept value on divide by zero)
//   o_res[63:0] - {HI,LO} to be committed when the operation completes
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [3:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [31:0] i_hi,
    input  logic [31:0] i_lo,
    output logic [63:0] o_res
);

    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_uq_s;
    logic [31:0] w_ur_s;
    logic [31:0] w_q_s;
    logic [31:0] w_r_s;
    logic [31:0] w_q_u;
    logic [31:0] w_r_u;
    logic        w_b_zero;

    // Low 64 bits of the sign-extended product equal the true signed product.
    assign w_prod_s = {{32{i_a[31]}}, i_a} * {{32{i_b[31]}}, i_b};
    assign w_prod_u = {32'd0, i_a} * {32'd0, i_b};

    // Signed divide via magnitudes, so 0x80000000 / -1 yields 0x80000000 rem 0
    // without relying on signed-overflow behaviour of the divider.
    assign w_b_zero = (i_b == 32'd0);
    assign w_a_neg  = i_a[31];
    assign w_b_neg  = i_b[31];
    assign w_a_mag  = w_a_neg ? (32'd0 - i_a) : i_a;
    assign w_b_mag  = w_b_neg ? (32'd0 - i_b) : i_b;
    assign w_uq_s   = w_b_zero ? 32'd0 : (w_a_mag / w_b_mag);
    assign w_ur_s   = w_b_zero ? 32'd0 : (w_a_mag % w_b_mag);
    assign w_q_s    = (w_a_neg ^ w_b_neg) ? (32'd0 - w_uq_s) : w_uq_s;
    assign w_r_s    = w_a_neg ? (32'd0 - w_ur_s) : w_ur_s;
    assign w_q_u    = w_b_zero ? 32'd0 : (i_a / i_b);
    assign w_r_u    = w_b_zero ? 32'd0 : (i_a % i_b);

    always_comb begin
        o_res = {i_hi, i_lo};
        case (i_op)
            MD_MULT:  o_res = w_prod_s;
            MD_MULTU: o_res = w_prod_u;
            MD_DIV:   if (!w_b_zero) o_res = {w_r_s, w_q_s};
            MD_DIVU:  if (!w_b_zero) o_res = {w_r_u, w_q_u};
`ifdef MDU_MADD_EN
            MD_MADD:  o_res = {i_hi, i_lo} + w_prod_s;
            MD_MADDU: o_res = {i_hi, i_lo} + w_prod_u;
            MD_MSUB:  o_res = {i_hi, i_lo} - w_prod_s;
            MD_MSUBU: o_res = {i_hi, i_lo} - w_prod_u;
`endif
            default:  o_res = {i_hi, i_lo};
        endcase
    end

endmodule

// File: rtl/e_mdu.sv
// rtl/e_mdu.sv - execute-stage multiply/divide unit holding architectural HI/LO
//
// Optional feature macro: MDU_MADD_EN (MADD/MADDU/MSUB/MSUBU; otherwise those codes act as NONE).
// Parameters: MULT_CYCLES (1..31), DIV_CYCLES (1..31) - busy cycles per op class.
// Ports:
//   clk        - rising-edge clock
//   reset      - synchronous active-high, clears HI/LO, counter and pending result
//   mdu.slave  - md_en/md_op/A/B in; busy/stall_req/HI/LO/MDOUT out
module e_mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic   clk,
    input  logic   reset,
    e_mdu_if.slave mdu
);

    localparam logic [MDU_CNT_W-1:0] LP_MULT_CNT = MDU_CNT_W'(MULT_CYCLES);
    localparam logic [MDU_CNT_W-1:0] LP_DIV_CNT  = MDU_CNT_W'(DIV_CYCLES);
    localparam logic [MDU_CNT_W-1:0] LP_ONE      = MDU_CNT_W'(1);

    logic [MDU_CNT_W-1:0] r_cnt;
    logic [31:0]          r_hi;
    logic [31:0]          r_lo;
    logic [31:0]          r_pend_hi;
    logic [31:0]          r_pend_lo;
    logic                 w_busy;
    logic [63:0]          w_res;

    assign w_busy = (r_cnt != '0);

    mdu_arith u_arith (
        .i_op  (mdu.md_op),
        .i_a   (mdu.A),
        .i_b   (mdu.B),
        .i_hi  (r_hi),
        .i_lo  (r_lo),
        .o_res (w_res)
    );

    // While busy, md_en is ignored; HI/LO cannot change until the commit,
    // so the divide-by-zero "keep old value" result captured at accept is still exact.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_pend_hi <= '0;
            r_pend_lo <= '0;
        end else if (w_busy) begin
            r_cnt <= r_cnt - LP_ONE;
            if (r_cnt == LP_ONE) begin
                r_hi <= r_pend_hi;
                r_lo <= r_pend_lo;
            end
        end else if (mdu.md_en) begin
            if (is_mul_op(mdu.md_op)) begin
                r_cnt     <= LP_MULT_CNT;
                r_pend_hi <= w_res[63:32];
                r_pend_lo <= w_res[31:0];
            end else if (is_div_op(mdu.md_op)) begin
                r_cnt     <= LP_DIV_CNT;
                r_pend_hi <= w_res[63:32];
                r_pend_lo <= w_res[31:0];
            end else if (mdu.md_op == MD_MTHI) begin
                r_hi <= mdu.A;
            end else if (mdu.md_op == MD_MTLO) begin
                r_lo <= mdu.A;
            end
        end
    end

    assign mdu.busy      = w_busy;
    assign mdu.stall_req = w_busy | (mdu.md_en & is_md_op(mdu.md_op));
    assign mdu.HI        = r_hi;
    assign mdu.LO        = r_lo;
    assign mdu.MDOUT     = (mdu.md_en && mdu.md_op == MD_MFHI) ? r_hi :
                           (mdu.md_en && mdu.md_op == MD_MFLO) ? r_lo : 32'd0;

endmodule

// File: tb/tb_e_mdu.sv
// tb/tb_e_mdu.sv - self-checking scoreboard bench for e_mdu
module tb_e_mdu;
    import mdu_pkg::*;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    e_mdu_if mif();

    e_mdu #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk   (clk),
        .reset (reset),
        .mdu   (mif.slave)
    );

    int          checks = 0;
    int          errors = 0;
    logic [63:0] sb_q[$];
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference {HI,LO} after an op, using 64-bit bench arithmetic.
    function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, q, r;
        longint unsigned ua, ub;
        logic [63:0]     acc;
        sa  = $signed(a);
        sb  = $signed(b);
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        acc = {m_hi, m_lo};
        case (op)
            MD_MULT:  return sa * sb;
            MD_MULTU: return ua * ub;
            MD_DIV: begin
                if (b == 32'd0) return acc;
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            MD_DIVU: begin
                if (b == 32'd0) return acc;
                q = longint'(ua / ub);
                r = longint'(ua % ub);
                return {r[31:0], q[31:0]};
            end
`ifdef MDU_MADD_EN
            MD_MADD:  return acc + 64'(sa * sb);
            MD_MADDU: return acc + ua * ub;
            MD_MSUB:  return acc - 64'(sa * sb);
            MD_MSUBU: return acc - ua * ub;
`endif
            default:  return acc;
        endcase
    endfunction

    // Issue a mult/div class op; optionally keep md_en high with MTLO during busy.
    task automatic run_md(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int n, input logic hold, input logic [31:0] hold_val);
        int          cyc;
        logic        stall_ok;
        logic [63:0] exp;
        @(negedge clk);
        mif.md_en = 1'b1;
        mif.md_op = op;
        mif.A     = a;
        mif.B     = b;
        #1;
        check({tag, " stall_at_issue"}, 64'(mif.stall_req), 64'd1);
        sb_q.push_back(model(op, a, b));
        @(posedge clk);
        #1;
        if (hold) begin
            mif.md_op = MD_MTLO;
            mif.A     = hold_val;
        end else begin
            mif.md_en = 1'b0;
        end
        cyc      = 0;
        stall_ok = 1'b1;
        while (mif.busy && cyc < 200) begin
            cyc++;
            if (!mif.stall_req) stall_ok = 1'b0;
            @(posedge clk);
            #1;
        end
        check({tag, " busy_cycles"}, 64'(cyc), 64'(n));
        check({tag, " stall_while_busy"}, 64'(stall_ok), 64'd1);
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard: got empty queue expected entry", tag);
        end else begin
            exp = sb_q.pop_front();
            check({tag, " HI"}, 64'(mif.HI), 64'(exp[63:32]));
            check({tag, " LO"}, 64'(mif.LO), 64'(exp[31:0]));
            m_hi = exp[63:32];
            m_lo = exp[31:0];
        end
        if (hold) begin
            check({tag, " stall_after_commit"}, 64'(mif.stall_req), 64'd1);
            @(posedge clk);
            #1;
            mif.md_en = 1'b0;
            check({tag, " late_MTLO"}, 64'(mif.LO), 64'(hold_val));
            check({tag, " HI_kept"}, 64'(mif.HI), 64'(m_hi));
            m_lo = hold_val;
        end
    endtask

    initial begin
        reset     = 1'b1;
        mif.md_en = 1'b0;
        mif.md_op = MD_NONE;
        mif.A     = 32'd0;
        mif.B     = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset busy", 64'(mif.busy), 64'd0);
        check("reset HI", 64'(mif.HI), 64'd0);
        check("reset LO", 64'(mif.LO), 64'd0);
        check("reset stall_req", 64'(mif.stall_req), 64'd0);

        run_md("MULT", MD_MULT, 32'hFFFF_FFFE, 32'd3, MULT_N, 1'b0, 32'd0);
        check("MULT HI const", 64'(mif.HI), 64'h0000_0000_FFFF_FFFF);
        check("MULT LO const", 64'(mif.LO), 64'h0000_0000_FFFF_FFFA);

        @(negedge clk);
        mif.md_en = 1'b1;
        mif.md_op = MD_MFHI;
        #1;
        check("MFHI MDOUT", 64'(mif.MDOUT), 64'h0000_0000_FFFF_FFFF);
        check("MFHI stall_req", 64'(mif.stall_req), 64'd1);
        mif.md_op = MD_MFLO;
        #1;
        check("MFLO MDOUT", 64'(mif.MDOUT), 64'h0000_0000_FFFF_FFFA);
        mif.md_en = 1'b0;
        #1;
        check("idle MDOUT", 64'(mif.MDOUT), 64'd0);

        run_md("MULTU", MD_MULTU, 32'hFFFF_FFFE, 32'd3, MULT_N, 1'b0, 32'd0);
        check("MULTU HI const", 64'(mif.HI), 64'h0000_0000_0000_0002);

        run_md("DIV", MD_DIV, 32'hFFFF_FFF9, 32'd2, DIV_N, 1'b0, 32'd0);
        check("DIV LO const", 64'(mif.LO), 64'h0000_0000_FFFF_FFFD);
        check("DIV HI const", 64'(mif.HI), 64'h0000_0000_FFFF_FFFF);

        run_md("DIV_OVF", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, DIV_N, 1'b0, 32'd0);
        check("DIV_OVF LO const", 64'(mif.LO), 64'h0000_0000_8000_0000);
        check("DIV_OVF HI const", 64'(mif.HI), 64'd0);

        @(negedge clk);
        mif.md_en = 1'b1;
        mif.md_op = MD_MTHI;
        mif.A     = 32'h1234_5678;
        @(posedge clk);
        #1;
        mif.md_en = 1'b0;
        check("MTHI HI", 64'(mif.HI), 64'h0000_0000_1234_5678);
        check("MTHI busy", 64'(mif.busy), 64'd0);
        m_hi = 32'h1234_5678;

        run_md("DIVU0", MD_DIVU, 32'd5, 32'd0, DIV_N, 1'b0, 32'd0);
        check("DIVU0 HI const", 64'(mif.HI), 64'h0000_0000_1234_5678);

        @(negedge clk);
        mif.md_en = 1'b1;
        mif.md_op = MD_NONE;
        mif.A     = 32'hDEAD_BEEF;
        #1;
        check("NONE stall_req", 64'(mif.stall_req), 64'd0);
        mif.md_op = 4'd13;
        #1;
        check("unknown stall_req", 64'(mif.stall_req), 64'd0);
`ifndef MDU_MADD_EN
        mif.md_op = MD_MADD;
        #1;
        check("MADD_off stall_req", 64'(mif.stall_req), 64'd0);
`endif
        @(posedge clk);
        #1;
        mif.md_en = 1'b0;
        check("unknown busy", 64'(mif.busy), 64'd0);
        check("unknown HI", 64'(mif.HI), 64'(m_hi));
        check("unknown LO", 64'(mif.LO), 64'(m_lo));

`ifdef MDU_MADD_EN
        run_md("MADD", MD_MADD, 32'hFFFF_FFFF, 32'd7, MULT_N, 1'b0, 32'd0);
        run_md("MSUBU", MD_MSUBU, 32'h8000_0000, 32'd4, MULT_N, 1'b0, 32'd0);
`endif

        run_md("MULT_HOLD", MD_MULT, 32'h0001_0003, 32'h0000_0100, MULT_N, 1'b1, 32'hCAFE_F00D);

        // Reset during the 4th busy cycle of a divide discards the pending result.
        @(negedge clk);
        mif.md_en = 1'b1;
        mif.md_op = MD_DIV;
        mif.A     = 32'd100;
        mif.B     = 32'd7;
        @(posedge clk);
        #1;
        mif.md_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("pre_reset busy", 64'(mif.busy), 64'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb_q.delete();
        m_hi = 32'd0;
        m_lo = 32'd0;
        check("midreset busy", 64'(mif.busy), 64'd0);
        check("midreset HI", 64'(mif.HI), 64'd0);
        check("midreset LO", 64'(mif.LO), 64'd0);
        repeat (12) @(posedge clk);
        #1;
        check("no_late_commit HI", 64'(mif.HI), 64'd0);
        check("no_late_commit LO", 64'(mif.LO), 64'd0);
        check("no_late_commit busy", 64'(mif.busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
